// File: rtl/ofex_operand_stage.sv
// ---------------------------------------------------------------------------
// ofex_operand_stage
//
// Purpose:
//   Pipeline register between operand-fetch (OF) and execute (EX), together
//   with the EX-side operand resolver. The stage captures the decoded
//   instruction and the register-file read data from OF. It holds the
//   instruction across stalls and keeps the held operands up to date from
//   forwarding and write-back traffic. A flush or an empty OF slot loads a
//   bubble instead of an instruction.
//
// Port summary:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   stall_ofex, flush          hazard-controller hold / kill requests
//   of_*                       decoded instruction presented by OF
//   rf_rs1_data, rf_rs2_data   register-file read data for of_rs1/2_sel
//   fwd_rs*_enable/_data       forwarding packet for the EX-resident sources
//   wb_enable/addr/data        register-file write port (this cycle)
//   ex_*                       instruction and resolved operands in EX
//   stall_cnt, bubble_cnt      saturating performance counters
// ---------------------------------------------------------------------------
module ofex_operand_stage #(
  parameter int              XLEN     = 32,
  parameter int              CNT_W    = 16,
  parameter logic [XLEN-1:0] NOP_INSN = 'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_ofex,
  input  logic             flush,
  input  logic             of_valid,
  input  logic [XLEN-1:0]  of_instr,
  input  logic [XLEN-1:0]  of_pc,
  input  logic [4:0]       of_rs1_sel,
  input  logic [4:0]       of_rs2_sel,
  input  logic [4:0]       of_rd_sel,
  input  logic             of_wb_enable,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             fwd_rs1_enable,
  input  logic [XLEN-1:0]  fwd_rs1_data,
  input  logic             fwd_rs2_enable,
  input  logic [XLEN-1:0]  fwd_rs2_data,
  input  logic             wb_enable,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_instr,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rd_sel,
  output logic             ex_wb_enable,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q;
  logic [XLEN-1:0]  instr_q;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       rdSel_q;
  logic             wbEnable_q;
  logic [4:0]       rs1Sel_q;
  logic [4:0]       rs2Sel_q;
  logic [XLEN-1:0]  op1_q;
  logic [XLEN-1:0]  op1_d;
  logic [XLEN-1:0]  op2_q;
  logic [XLEN-1:0]  op2_d;
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] stallCnt_d;
  logic [CNT_W-1:0] bubbleCnt_q;
  logic [CNT_W-1:0] bubbleCnt_d;

  logic load;
  logic loadBubble;
  logic refresh;
  logic wbHitOf1;
  logic wbHitOf2;
  logic wbHitEx1;
  logic wbHitEx2;

  // A load happens on every unstalled edge; stall wins over flush so a
  // flush raised while stalled is simply dropped.
  assign load       = !stall_ofex;
  assign loadBubble = load && (flush || !of_valid);
  assign refresh    = stall_ofex && (state_q != ST_EMPTY);

  // Write-back hits. x0 is never a real destination, so it never matches.
  assign wbHitOf1 = wb_enable && (wb_addr == of_rs1_sel) && (of_rs1_sel != 5'd0);
  assign wbHitOf2 = wb_enable && (wb_addr == of_rs2_sel) && (of_rs2_sel != 5'd0);
  assign wbHitEx1 = wb_enable && (wb_addr == rs1Sel_q) && (rs1Sel_q != 5'd0);
  assign wbHitEx2 = wb_enable && (wb_addr == rs2Sel_q) && (rs2Sel_q != 5'd0);

  // Operand register next-state. On a load the regfile value is taken,
  // except when the same-cycle write-back targets the source register:
  // the regfile read does not see that write yet, so wb_data is bypassed.
  // While a valid instruction sits stalled, a forward pulse is captured so
  // it survives after the producer stops driving it; a forward beats a
  // write-back that lands in the same cycle because it is the younger value.
  always_comb begin
    op1_d = op1_q;
    op2_d = op2_q;
    if (load) begin
      if (loadBubble) begin
        op1_d = '0;
        op2_d = '0;
      end else begin
        op1_d = wbHitOf1 ? wb_data : rf_rs1_data;
        op2_d = wbHitOf2 ? wb_data : rf_rs2_data;
      end
    end else if (refresh) begin
      if (fwd_rs1_enable) begin
        op1_d = fwd_rs1_data;
      end else if (wbHitEx1) begin
        op1_d = wb_data;
      end
      if (fwd_rs2_enable) begin
        op2_d = fwd_rs2_data;
      end else if (wbHitEx2) begin
        op2_d = wb_data;
      end
    end
  end

  // Saturating performance counters: they stick at all-ones instead of
  // wrapping so a long run never reports a misleadingly small number.
  always_comb begin
    stallCnt_d  = stallCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    if (refresh && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
    if (loadBubble && (bubbleCnt_q != {CNT_W{1'b1}})) begin
      bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
    end
  end

  // Stage FSM and pipeline register. A bubble loads the canonical NOP with
  // zeroed side fields so downstream logic never sees stale control bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      instr_q     <= NOP_INSN;
      pc_q        <= '0;
      rdSel_q     <= 5'd0;
      wbEnable_q  <= 1'b0;
      rs1Sel_q    <= 5'd0;
      rs2Sel_q    <= 5'd0;
      op1_q       <= '0;
      op2_q       <= '0;
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      case (state_q)
        ST_EMPTY, ST_ISSUE, ST_HOLD: begin
          if (loadBubble) begin
            state_q    <= ST_EMPTY;
            instr_q    <= NOP_INSN;
            pc_q       <= '0;
            rdSel_q    <= 5'd0;
            wbEnable_q <= 1'b0;
            rs1Sel_q   <= 5'd0;
            rs2Sel_q   <= 5'd0;
          end else if (load) begin
            state_q    <= ST_ISSUE;
            instr_q    <= of_instr;
            pc_q       <= of_pc;
            rdSel_q    <= of_rd_sel;
            wbEnable_q <= of_wb_enable;
            rs1Sel_q   <= of_rs1_sel;
            rs2Sel_q   <= of_rs2_sel;
          end else if (state_q != ST_EMPTY) begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign ex_valid     = (state_q != ST_EMPTY);
  assign ex_instr     = instr_q;
  assign ex_pc        = pc_q;
  assign ex_rd_sel    = rdSel_q;
  assign ex_wb_enable = wbEnable_q;
  assign stall_cnt    = stallCnt_q;
  assign bubble_cnt   = bubbleCnt_q;

  // Operand resolve: x0 is hard zero, then a live forward, then the held
  // (already refreshed) operand register.
  assign ex_rs1_data = (rs1Sel_q == 5'd0) ? '0 :
                       fwd_rs1_enable     ? fwd_rs1_data : op1_q;
  assign ex_rs2_data = (rs2Sel_q == 5'd0) ? '0 :
                       fwd_rs2_enable     ? fwd_rs2_data : op2_q;

endmodule

// File: tb/tb_ofex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ofex_operand_stage
//
// Self-checking bench for ofex_operand_stage (built with 4-bit counters so
// saturation is reachable). A behavioural model predicts every output; the
// prediction is queued when a cycle's stimulus is driven and compared once
// the DUT has produced the corresponding output.
// ---------------------------------------------------------------------------
module tb_ofex_operand_stage;

  localparam int          XLEN = 32;
  localparam int          CW   = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            stall_ofex;
  logic            flush;
  logic            of_valid;
  logic [31:0]     of_instr;
  logic [31:0]     of_pc;
  logic [4:0]      of_rs1_sel;
  logic [4:0]      of_rs2_sel;
  logic [4:0]      of_rd_sel;
  logic            of_wb_enable;
  logic [31:0]     rf_rs1_data;
  logic [31:0]     rf_rs2_data;
  logic            fwd_rs1_enable;
  logic [31:0]     fwd_rs1_data;
  logic            fwd_rs2_enable;
  logic [31:0]     fwd_rs2_data;
  logic            wb_enable;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            ex_valid;
  logic [31:0]     ex_instr;
  logic [31:0]     ex_pc;
  logic [4:0]      ex_rd_sel;
  logic            ex_wb_enable;
  logic [31:0]     ex_rs1_data;
  logic [31:0]     ex_rs2_data;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   bubble_cnt;

  ofex_operand_stage #(
    .XLEN    (XLEN),
    .CNT_W   (CW),
    .NOP_INSN(NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_ofex    (stall_ofex),
    .flush         (flush),
    .of_valid      (of_valid),
    .of_instr      (of_instr),
    .of_pc         (of_pc),
    .of_rs1_sel    (of_rs1_sel),
    .of_rs2_sel    (of_rs2_sel),
    .of_rd_sel     (of_rd_sel),
    .of_wb_enable  (of_wb_enable),
    .rf_rs1_data   (rf_rs1_data),
    .rf_rs2_data   (rf_rs2_data),
    .fwd_rs1_enable(fwd_rs1_enable),
    .fwd_rs1_data  (fwd_rs1_data),
    .fwd_rs2_enable(fwd_rs2_enable),
    .fwd_rs2_data  (fwd_rs2_data),
    .wb_enable     (wb_enable),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .ex_valid      (ex_valid),
    .ex_instr      (ex_instr),
    .ex_pc         (ex_pc),
    .ex_rd_sel     (ex_rd_sel),
    .ex_wb_enable  (ex_wb_enable),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt)
  );

  typedef struct {
    logic          valid;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [4:0]    rd;
    logic          wben;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state (0 = empty, 1 = first EX cycle, 2 = stalled).
  int            mState;
  logic [31:0]   mInstr, mPc, mOp1, mOp2;
  logic [4:0]    mRd, mS1, mS2;
  logic          mWben;
  logic [CW-1:0] mSc, mBc;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Forward pulses are visible immediately, x0 always reads zero.
  function automatic logic [31:0] resolve(input logic [4:0] sel, input logic fen,
                                          input logic [31:0] fdat,
                                          input logic [31:0] held);
    if (sel == 5'd0) return 32'd0;
    if (fen) return fdat;
    return held;
  endfunction

  task automatic pushExpected();
    exp_t e;
    e.valid = (mState != 0);
    e.instr = mInstr;
    e.pc    = mPc;
    e.rd    = mRd;
    e.wben  = mWben;
    e.rs1   = resolve(mS1, fwd_rs1_enable, fwd_rs1_data, mOp1);
    e.rs2   = resolve(mS2, fwd_rs2_enable, fwd_rs2_data, mOp2);
    e.sc    = mSc;
    e.bc    = mBc;
    sbQ.push_back(e);
  endtask

  task automatic popAndCompare(input string ph);
    exp_t e;
    if (sbQ.size() == 0) begin
      checkOutput({ph, "_queueEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    checkOutput({ph, "_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
    checkOutput({ph, "_instr"}, ex_instr, e.instr);
    checkOutput({ph, "_pc"}, ex_pc, e.pc);
    checkOutput({ph, "_rd"}, {27'd0, ex_rd_sel}, {27'd0, e.rd});
    checkOutput({ph, "_wben"}, {31'd0, ex_wb_enable}, {31'd0, e.wben});
    checkOutput({ph, "_rs1"}, ex_rs1_data, e.rs1);
    checkOutput({ph, "_rs2"}, ex_rs2_data, e.rs2);
    checkOutput({ph, "_stallCnt"}, {28'd0, stall_cnt}, {28'd0, e.sc});
    checkOutput({ph, "_bubbleCnt"}, {28'd0, bubble_cnt}, {28'd0, e.bc});
  endtask

  task automatic modelReset();
    mState = 0; mInstr = NOP; mPc = 0; mRd = 0; mWben = 0;
    mS1 = 0; mS2 = 0; mOp1 = 0; mOp2 = 0; mSc = 0; mBc = 0;
  endtask

  // Model of one rising edge, evaluated with the inputs present at the edge.
  task automatic modelEdge();
    logic [31:0] n1, n2;
    if (reset) begin
      modelReset();
    end else if (!stall_ofex) begin
      if (flush || !of_valid) begin
        mState = 0; mInstr = NOP; mPc = 0; mRd = 0; mWben = 0;
        mS1 = 0; mS2 = 0; mOp1 = 0; mOp2 = 0;
        if (mBc != 4'hF) mBc = mBc + 1;
      end else begin
        mState = 1; mInstr = of_instr; mPc = of_pc; mRd = of_rd_sel;
        mWben = of_wb_enable; mS1 = of_rs1_sel; mS2 = of_rs2_sel;
        mOp1 = (wb_enable && wb_addr == of_rs1_sel && of_rs1_sel != 0) ? wb_data : rf_rs1_data;
        mOp2 = (wb_enable && wb_addr == of_rs2_sel && of_rs2_sel != 0) ? wb_data : rf_rs2_data;
      end
    end else if (mState != 0) begin
      n1 = mOp1;
      n2 = mOp2;
      if (fwd_rs1_enable) n1 = fwd_rs1_data;
      else if (wb_enable && wb_addr == mS1 && mS1 != 0) n1 = wb_data;
      if (fwd_rs2_enable) n2 = fwd_rs2_data;
      else if (wb_enable && wb_addr == mS2 && mS2 != 0) n2 = wb_data;
      mOp1 = n1;
      mOp2 = n2;
      mState = 2;
      if (mSc != 4'hF) mSc = mSc + 1;
    end
  endtask

  // One clock cycle: inputs are already driven (just after a falling edge).
  // Checks the combinational view before the edge and the registered view
  // after it, then returns on the next falling edge.
  task automatic applyStimulus();
    pushExpected();
    #1 popAndCompare("pre");
    @(posedge clk);
    modelEdge();
    pushExpected();
    #1 popAndCompare("post");
    @(negedge clk);
  endtask

  task automatic idleInputs();
    reset = 0; stall_ofex = 0; flush = 0; of_valid = 0;
    of_instr = 0; of_pc = 0; of_rs1_sel = 0; of_rs2_sel = 0; of_rd_sel = 0;
    of_wb_enable = 0; rf_rs1_data = 0; rf_rs2_data = 0;
    fwd_rs1_enable = 0; fwd_rs1_data = 0; fwd_rs2_enable = 0; fwd_rs2_data = 0;
    wb_enable = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic driveInstr(input logic [31:0] instr, input logic [31:0] pc,
                            input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] rd, input logic [31:0] d1,
                            input logic [31:0] d2);
    of_valid = 1; of_instr = instr; of_pc = pc; of_rs1_sel = s1; of_rs2_sel = s2;
    of_rd_sel = rd; of_wb_enable = 1; rf_rs1_data = d1; rf_rs2_data = d2;
  endtask

  initial begin
    idleInputs();
    reset = 1;
    repeat (2) @(posedge clk);
    modelReset();
    @(negedge clk);

    // Reset state, still in reset.
    applyStimulus();
    checkOutput("resetInstr", ex_instr, NOP);

    // Empty OF slot loads a bubble.
    reset = 0;
    applyStimulus();
    checkOutput("bubbleCount", {28'd0, bubble_cnt}, 32'd1);

    // Load x5 (rf 7), then forward 9 while stalled; forward must stick.
    driveInstr(32'h0050_0293, 32'h100, 5'd5, 5'd6, 5'd1, 32'd7, 32'd11);
    applyStimulus();
    checkOutput("loadRs1", ex_rs1_data, 32'd7);
    of_valid = 0;
    stall_ofex = 1; fwd_rs1_enable = 1; fwd_rs1_data = 32'd9;
    #1 checkOutput("fwdLive", ex_rs1_data, 32'd9);
    applyStimulus();
    fwd_rs1_enable = 0; fwd_rs1_data = 0;
    #1 checkOutput("fwdHeld", ex_rs1_data, 32'd9);
    checkOutput("stallOne", {28'd0, stall_cnt}, 32'd1);
    applyStimulus();

    // rs2 = x0 ignores a forward.
    stall_ofex = 0;
    driveInstr(32'h0000_0033, 32'h104, 5'd2, 5'd0, 5'd4, 32'd3, 32'd55);
    applyStimulus();
    stall_ofex = 1; fwd_rs2_enable = 1; fwd_rs2_data = 32'hDEAD;
    #1 checkOutput("x0Fwd", ex_rs2_data, 32'd0);
    applyStimulus();
    fwd_rs2_enable = 0;

    // Stall and flush together: instruction retained, no bubble counted.
    flush = 1;
    applyStimulus();
    checkOutput("stallFlushValid", {31'd0, ex_valid}, 32'd1);
    checkOutput("stallFlushPc", ex_pc, 32'h104);
    checkOutput("stallFlushBubble", {28'd0, bubble_cnt}, 32'd1);
    flush = 0;

    // Write-through bypass on load.
    stall_ofex = 0;
    driveInstr(32'h0031_8193, 32'h108, 5'd3, 5'd7, 5'd3, 32'd1, 32'd2);
    wb_enable = 1; wb_addr = 5'd3; wb_data = 32'd42;
    applyStimulus();
    checkOutput("wbBypass", ex_rs1_data, 32'd42);
    wb_enable = 0;

    // Write-back refresh while held, then a long hold to saturate.
    of_valid = 0; stall_ofex = 1;
    wb_enable = 1; wb_addr = 5'd7; wb_data = 32'h77;
    applyStimulus();
    wb_enable = 0;
    checkOutput("wbRefresh", ex_rs2_data, 32'h77);
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("stallSat", {28'd0, stall_cnt}, 32'd15);

    // Reset for 2 cycles in the middle of a hold.
    reset = 1;
    applyStimulus();
    applyStimulus();
    reset = 0;
    checkOutput("midHoldResetValid", {31'd0, ex_valid}, 32'd0);
    checkOutput("midHoldResetInstr", ex_instr, NOP);
    checkOutput("midHoldResetStall", {28'd0, stall_cnt}, 32'd0);
    stall_ofex = 0;

    // Randomised traffic with small register indices to force collisions.
    for (int i = 0; i < 300; i++) begin
      reset          = ($urandom_range(0, 59) == 0);
      stall_ofex     = ($urandom_range(0, 1) == 1);
      flush          = ($urandom_range(0, 5) == 0);
      of_valid       = ($urandom_range(0, 3) != 0);
      of_instr       = $urandom;
      of_pc          = $urandom;
      of_rs1_sel     = 5'($urandom_range(0, 3));
      of_rs2_sel     = 5'($urandom_range(0, 3));
      of_rd_sel      = 5'($urandom_range(0, 31));
      of_wb_enable   = 1'($urandom_range(0, 1));
      rf_rs1_data    = $urandom;
      rf_rs2_data    = $urandom;
      fwd_rs1_enable = ($urandom_range(0, 3) == 0);
      fwd_rs1_data   = $urandom;
      fwd_rs2_enable = ($urandom_range(0, 3) == 0);
      fwd_rs2_data   = $urandom;
      wb_enable      = ($urandom_range(0, 1) == 1);
      wb_addr        = 5'($urandom_range(0, 3));
      wb_data        = $urandom;
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
